// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core.
// Holds the opcode/funct encodings, the ALU operation set and a sign-extension helper.
// Pure definitions: no logic, no timing.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {ADD, SUB, AND, OR, NOR, SLT} alu_op_e;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_single_cycle_cpu_if.sv
// Word-addressed memory bus between the core and its instruction/data memories.
// Reads are combinational (zero latency); writes commit on the next rising clock.
// No backpressure: every access completes in the cycle it is presented.
interface mips_single_cycle_cpu_if #(parameter int IW = 10);
  logic [IW-1:0] addr;
  logic [31:0]   wdata;
  logic          we;
  logic [31:0]   rdata;

  modport master (output addr, wdata, we, input rdata);
  modport slave  (input addr, wdata, we, output rdata);
endinterface

// File: rtl/mips_single_cycle_cpu_mem.sv
// Single-port word memory used for both instruction and data storage.
// Combinational read, write on rising clock when we is high.
// Never stalls; contents are not affected by reset.
module mips_mem #(
  parameter int WORDS = 1024
) (
  input logic clk,
  mips_single_cycle_cpu_if.slave bus
);

  logic [31:0] memory [0:WORDS-1];

  assign bus.rdata = memory[bus.addr];

  // Word write; the index is already reduced to the memory depth so addresses wrap.
  always_ff @(posedge clk) begin
    if (bus.we) begin
      memory[bus.addr] <= bus.wdata;
    end
  end

endmodule

// File: rtl/mips_single_cycle_cpu_regfile.sv
// 32x32 register file, two combinational read ports and one write port.
// Write lands on the rising edge; reads see the old value until then.
// Register 0 reads as zero and ignores writes.
module mips_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic [4:0]  waddr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] registers [0:31];

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : registers[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : registers[raddr2];

  // Synchronous clear on reset, otherwise a single write per cycle to a nonzero register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        registers[i] <= 32'd0;
      end
    end else if (we && (waddr != 5'd0)) begin
      registers[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/mips_single_cycle_cpu.sv
// Single-cycle MIPS core: fetch, decode, execute, memory and writeback in one clock.
// One instruction retires per cycle; PC, register file and data memory update on the same edge.
// No stalls; unsupported encodings retire as NOPs.
module mips_single_cycle_cpu
  import mips_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic clk,
  input logic reset
);

  localparam int IMEM_IW = $clog2(IMEM_WORDS);
  localparam int DMEM_IW = $clog2(DMEM_WORDS);

  logic [31:0] pc_reg;
  logic [31:0] instruction;
  logic [31:0] next_pc;

  mips_single_cycle_cpu_if #(.IW(IMEM_IW)) imem_bus ();
  mips_single_cycle_cpu_if #(.IW(DMEM_IW)) dmem_bus ();

  mips_mem #(.WORDS(IMEM_WORDS)) imem (.clk(clk), .bus(imem_bus.slave));
  mips_mem #(.WORDS(DMEM_WORDS)) dmem (.clk(clk), .bus(dmem_bus.slave));

  // Instruction side is read-only from the core.
  assign imem_bus.addr  = pc_reg[IMEM_IW+1:2];
  assign imem_bus.wdata = 32'd0;
  assign imem_bus.we    = 1'b0;
  assign instruction    = imem_bus.rdata;

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext;
  logic [4:0]  unused_shamt;

  assign opcode       = instruction[31:26];
  assign rs           = instruction[25:21];
  assign rt           = instruction[20:16];
  assign rd           = instruction[15:11];
  assign unused_shamt = instruction[10:6];
  assign funct        = instruction[5:0];
  assign imm_ext      = sign_ext16(instruction[15:0]);

  // Control signals
  logic    reg_write, reg_dst, alu_src, mem_write, mem_to_reg, branch, jump;
  alu_op_e alu_op;

  // Main decode: anything not recognised leaves every enable low and so behaves as a NOP.
  always_comb begin
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_op     = ADD;
    case (opcode)
      OP_RTYPE: begin
        reg_dst = 1'b1;
        case (funct)
          FN_ADD:  begin reg_write = 1'b1; alu_op = ADD; end
          FN_SUB:  begin reg_write = 1'b1; alu_op = SUB; end
          FN_AND:  begin reg_write = 1'b1; alu_op = AND; end
          FN_OR:   begin reg_write = 1'b1; alu_op = OR;  end
          FN_NOR:  begin reg_write = 1'b1; alu_op = NOR; end
          FN_SLT:  begin reg_write = 1'b1; alu_op = SLT; end
          default: reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin reg_write = 1'b1; alu_src = 1'b1; end
      OP_LW:   begin reg_write = 1'b1; alu_src = 1'b1; mem_to_reg = 1'b1; end
      OP_SW:   begin alu_src = 1'b1; mem_write = 1'b1; end
      OP_BEQ:  branch = 1'b1;
      OP_J:    jump = 1'b1;
      default: reg_write = 1'b0;
    endcase
  end

  // Register file
  logic [31:0] rs_val, rt_val, wb_data;
  logic [4:0]  wb_addr;

  assign wb_addr = reg_dst ? rd : rt;

  mips_regfile REG_FILE (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs),
    .raddr2 (rt),
    .waddr  (wb_addr),
    .we     (reg_write),
    .wdata  (wb_data),
    .rdata1 (rs_val),
    .rdata2 (rt_val)
  );

  // ALU
  logic [31:0] alu_b, alu_result;

  assign alu_b = alu_src ? imm_ext : rt_val;

  // Arithmetic wraps silently; slt compares as two's-complement.
  always_comb begin
    case (alu_op)
      ADD:     alu_result = rs_val + alu_b;
      SUB:     alu_result = rs_val - alu_b;
      AND:     alu_result = rs_val & alu_b;
      OR:      alu_result = rs_val | alu_b;
      NOR:     alu_result = ~(rs_val | alu_b);
      SLT:     alu_result = {31'd0, $signed(rs_val) < $signed(alu_b)};
      default: alu_result = rs_val + alu_b;
    endcase
  end

  // Data memory: word access, low address bits dropped, upper bits beyond depth ignored.
  // The store is suppressed while reset is asserted.
  assign dmem_bus.addr  = alu_result[DMEM_IW+1:2];
  assign dmem_bus.wdata = rt_val;
  assign dmem_bus.we    = mem_write & reset;

  assign wb_data = mem_to_reg ? dmem_bus.rdata : alu_result;

  // Next PC
  logic [31:0] pc_plus4, branch_target, jump_target;

  assign pc_plus4      = pc_reg + 32'd4;
  assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instruction[25:0], 2'b00};

  // Select among sequential, taken-branch and jump targets.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && (rs_val == rt_val)) begin
      next_pc = branch_target;
    end
  end

  // PC register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= next_pc;
    end
  end

endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
// Bench for the single-cycle MIPS core: directed programs plus random programs,
// all checked every cycle against an instruction-level interpreter kept here.
module tb_mips_single_cycle_cpu;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mips_single_cycle_cpu #(
    .IMEM_WORDS(1024),
    .DMEM_WORDS(1024),
    .RESET_PC  (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset)
  );

  // Reference interpreter state
  logic [31:0] m_imem [0:1023];
  logic [31:0] m_dmem [0:1023];
  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc;

  int n_asserts = 0;
  int n_fail = 0;

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] target);
    return {6'h02, target};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  task automatic model_wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_regs[r] = v;
  endtask

  // Execute one instruction at the ISA level.
  task automatic model_exec();
    logic [31:0] ins, a, b, se, npc, ea;
    ins = m_imem[m_pc[11:2]];
    a   = m_regs[ins[25:21]];
    b   = m_regs[ins[20:16]];
    se  = {{16{ins[15]}}, ins[15:0]};
    npc = m_pc + 32'd4;
    ea  = a + se;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: model_wr(ins[15:11], a + b);
        6'h22: model_wr(ins[15:11], a - b);
        6'h24: model_wr(ins[15:11], a & b);
        6'h25: model_wr(ins[15:11], a | b);
        6'h27: model_wr(ins[15:11], ~(a | b));
        6'h2A: model_wr(ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        default: ;
      endcase
      6'h08: model_wr(ins[20:16], ea);
      6'h23: model_wr(ins[20:16], m_dmem[ea[11:2]]);
      6'h2B: m_dmem[ea[11:2]] = b;
      6'h04: if (a == b) npc = npc + (se << 2);
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    m_pc = npc;
  endtask

  task automatic compare_state();
    chk("pc", dut.pc_reg, m_pc);
    chk("fetch", dut.instruction, m_imem[m_pc[11:2]]);
    for (int i = 0; i < 32; i++) chk($sformatf("reg%0d", i), dut.REG_FILE.registers[i], m_regs[i]);
  endtask

  // One clock: advance the model alongside the DUT, then compare at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!reset) model_reset();
    else model_exec();
    @(negedge clk);
    compare_state();
  endtask

  task automatic load_prog(input logic [31:0] p[$]);
    for (int i = 0; i < 1024; i++) begin
      dut.imem.memory[i] = 32'd0;
      m_imem[i] = 32'd0;
    end
    for (int i = 0; i < p.size(); i++) begin
      dut.imem.memory[i] = p[i];
      m_imem[i] = p[i];
    end
  endtask

  task automatic set_dmem(input int idx, input logic [31:0] v);
    dut.dmem.memory[idx] = v;
    m_dmem[idx] = v;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) cycle();
    reset = 1'b1;
  endtask

  logic [31:0] prog[$];
  logic [31:0] trace [0:9];
  logic [5:0]  fns [0:5];

  initial begin
    trace = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd32, 32'd36, 32'd40, 32'd44};
    fns   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    for (int i = 0; i < 1024; i++) set_dmem(i, 32'd0);

    // Test 1/2 program loaded up front; registers dirtied before reset.
    prog = '{enc_i(6'h08, 0, 1, 16'd10), enc_i(6'h08, 0, 2, 16'd20), enc_r(1, 2, 3, 6'h20),
             enc_i(6'h2B, 0, 3, 16'd8), enc_i(6'h23, 0, 4, 16'd8), enc_i(6'h04, 4, 3, 16'd2),
             enc_r(1, 2, 5, 6'h22), enc_j(26'd9), enc_r(4, 1, 4, 6'h25),
             enc_r(1, 4, 6, 6'h2A), enc_r(4, 6, 7, 6'h27)};
    load_prog(prog);
    for (int i = 0; i < 32; i++) dut.REG_FILE.registers[i] = $urandom | 32'd1;
    model_reset();
    do_reset(2);
    chk("reset_pc", dut.pc_reg, 32'd0);
    chk("reset_r31", dut.REG_FILE.registers[31], 32'd0);

    // Test 2: PC trace and final values
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("pc_trace%0d", k), dut.pc_reg, trace[k]);
      if (k < 9) cycle();
    end
    chk("p1_r1", dut.REG_FILE.registers[1], 32'd10);
    chk("p1_r2", dut.REG_FILE.registers[2], 32'd20);
    chk("p1_r3", dut.REG_FILE.registers[3], 32'd30);
    chk("p1_dmem2", dut.dmem.memory[2], 32'd30);
    chk("p1_r4", dut.REG_FILE.registers[4], 32'd30);
    chk("p1_r5", dut.REG_FILE.registers[5], 32'd0);
    chk("p1_r6", dut.REG_FILE.registers[6], 32'd1);
    chk("p1_r7", dut.REG_FILE.registers[7], 32'hFFFFFFE0);

    // Test 3: branch not taken, then self-loop
    prog = '{enc_i(6'h08, 0, 1, 16'd1), enc_i(6'h04, 1, 0, 16'd5), enc_i(6'h04, 0, 0, 16'hFFFF)};
    load_prog(prog);
    do_reset(1);
    cycle();
    cycle();
    chk("beq_not_taken", dut.pc_reg, 32'd8);
    cycle();
    cycle();
    chk("beq_self_loop", dut.pc_reg, 32'd8);

    // Test 4: signed compare and wrap-around add
    prog = '{enc_i(6'h08, 0, 1, 16'hFFFF), enc_r(1, 0, 2, 6'h2A), enc_r(1, 1, 3, 6'h20)};
    load_prog(prog);
    do_reset(1);
    repeat (3) cycle();
    chk("slt_signed", dut.REG_FILE.registers[2], 32'd1);
    chk("add_wrap", dut.REG_FILE.registers[3], 32'hFFFFFFFE);

    // Test 5: $0 write discarded, zero word is a NOP
    prog = '{enc_i(6'h08, 0, 0, 16'd5), enc_r(0, 0, 1, 6'h20), 32'd0};
    load_prog(prog);
    do_reset(1);
    repeat (3) cycle();
    chk("r0_write_dropped", dut.REG_FILE.registers[1], 32'd0);
    chk("nop_pc", dut.pc_reg, 32'd12);

    // Test 6: reset mid-program while a store is pending; dmem keeps 30
    prog = '{enc_i(6'h08, 0, 3, 16'd77), enc_i(6'h2B, 0, 3, 16'd8)};
    load_prog(prog);
    do_reset(1);
    cycle();
    chk("pre_reset_r3", dut.REG_FILE.registers[3], 32'd77);
    reset = 1'b0;
    cycle();
    chk("mid_reset_pc", dut.pc_reg, 32'd0);
    chk("mid_reset_r3", dut.REG_FILE.registers[3], 32'd0);
    chk("mid_reset_dmem2", dut.dmem.memory[2], 32'd30);
    reset = 1'b1;

    // Random programs checked every cycle against the interpreter
    for (int p = 0; p < 5; p++) begin
      prog.delete();
      for (int i = 0; i < 48; i++) begin
        int kind, rs, rt, rd;
        kind = $urandom_range(0, 11);
        rs = $urandom_range(0, 7);
        rt = $urandom_range(0, 7);
        rd = $urandom_range(0, 7);
        case (kind)
          0, 1, 2, 3, 4, 5: prog.push_back(enc_r(rs, rt, rd, fns[$urandom_range(0, 5)]));
          6: prog.push_back(enc_i(6'h08, rs, rt, 16'($urandom)));
          7: prog.push_back(enc_i(6'h23, rs, rt, 16'($urandom)));
          8: prog.push_back(enc_i(6'h2B, rs, rt, 16'($urandom)));
          9: prog.push_back(enc_i(6'h04, rs, rt, 16'($urandom_range(0, 8)) - 16'd4));
          10: prog.push_back(enc_j(26'($urandom_range(0, 47))));
          default: prog.push_back($urandom);
        endcase
      end
      load_prog(prog);
      for (int i = 0; i < 1024; i++) set_dmem(i, $urandom);
      do_reset(1);
      repeat (150) cycle();
      for (int i = 0; i < 1024; i++) chk($sformatf("rand%0d_dmem%0d", p, i), dut.dmem.memory[i], m_dmem[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
